// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit.
//   muldiv_op_e     funct3 encodings of the M-extension ops
//   muldiv_state_e  control FSM states
//   MULDIV_STEPS    iterations of the shift-add / restoring-divide loops
//   DIV0_*/OVF_*    results for the divisions that bypass iteration
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } muldiv_state_e;

  localparam int          MULDIV_STEPS  = 32;
  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUOTIENT  = 32'h8000_0000;
  localparam logic [31:0] OVF_REMAINDER = 32'h0000_0000;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;
  localparam logic [31:0] MINUS_ONE     = 32'hFFFF_FFFF;

  // rs1 is treated as signed by every op except the fully unsigned ones.
  function automatic logic op_signed_a(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // rs2 is signed only for MUL/MULH/DIV/REM (MULHSU treats it unsigned).
  function automatic logic op_signed_b(input muldiv_op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// div_step: one combinational restoring-division step on magnitudes.
//   rem_in   partial remainder (always < divisor)
//   divisor  divisor magnitude
//   quo_in   dividend bits still to shift in (MSB first) / quotient so far
//   rem_out  next partial remainder
//   quo_out  quo_in shifted left with the new quotient bit in the LSB
module div_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic [XLEN-1:0] divisor,
  input  logic [XLEN-1:0] quo_in,
  output logic [XLEN-1:0] rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    // rem_in < divisor, so the shifted value always fits XLEN+1 bits.
    shifted = {rem_in, quo_in[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[XLEN]) begin
      rem_out = diff[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b1};
    end else begin
      rem_out = shifted[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide unit for the EX stage.
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   start     EX holds a valid M instruction
//   funct3    op select (muldiv_op_e)
//   operandA  forwarded rs1, operandB forwarded rs2
//   flush     kill the in-flight operation
//   stall     freeze IF/ID/EX while the op iterates
//   busy      FSM not idle
//   done      one-cycle pulse, result valid
//   result    rd write value (held until the next completion)
// Build option: define RV_MUL_SINGLECYCLE_EN for a single-cycle multiplier;
// division stays iterative in both builds.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operandA,
  input  logic [XLEN-1:0] operandB,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  muldiv_state_e state, state_next;
  muldiv_op_e    op;
  logic          sign_a, sign_b;
  logic [5:0]    cnt, cnt_n;
  logic [31:0]   acc_hi, acc_hi_n;   // product high word / remainder
  logic [31:0]   acc_lo, acc_lo_n;   // multiplier+product low / dividend+quotient
  logic [31:0]   opnd;               // multiplicand or divisor magnitude
  logic          res_load;
  logic [31:0]   res_n;
  logic [32:0]   mul_sum;
  logic [31:0]   div_rem, div_quo;

  muldiv_op_e    in_op;
  logic          in_sa, in_sb;
  logic [31:0]   abs_a, abs_b;
  logic          div_zero, div_ovf, accept;
  logic [31:0]   special_res;

  // Sign fix and word select, applied to the magnitude results.
  function automatic logic [31:0] finish_result(input muldiv_op_e fop, input logic sa,
                                                input logic sb, input logic [63:0] prod,
                                                input logic [31:0] quo, input logic [31:0] rem);
    logic [63:0] p;
    logic [31:0] q, r;
    p = (sa ^ sb) ? -prod : prod;
    q = (sa ^ sb) ? -quo : quo;
    r = sa ? -rem : rem;
    case (fop)
      OP_MUL:                       return p[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: return p[63:32];
      OP_DIV, OP_DIVU:              return q;
      default:                      return r;
    endcase
  endfunction

  assign in_op    = muldiv_op_e'(funct3);
  assign in_sa    = op_signed_a(in_op) & operandA[31];
  assign in_sb    = op_signed_b(in_op) & operandB[31];
  // INT_MIN negates to itself, which is still its correct unsigned magnitude.
  assign abs_a    = in_sa ? -operandA : operandA;
  assign abs_b    = in_sb ? -operandB : operandB;
  assign div_zero = funct3[2] & (operandB == '0);
  assign div_ovf  = ((in_op == OP_DIV) || (in_op == OP_REM)) &&
                    (operandA == INT_MIN) && (operandB == MINUS_ONE);
  assign accept   = (state == ST_IDLE) & start & ~flush;

  // funct3[1] separates REM/REMU from DIV/DIVU.
  assign special_res = div_zero ? (funct3[1] ? operandA : DIV0_QUOTIENT)
                                : (funct3[1] ? OVF_REMAINDER : OVF_QUOTIENT);

`ifdef RV_MUL_SINGLECYCLE_EN
  logic [63:0] fast_prod;
  assign fast_prod = {32'b0, abs_a} * {32'b0, abs_b};
`endif

  div_step #(.XLEN(32)) u_div_step (
    .rem_in  (acc_hi),
    .divisor (opnd),
    .quo_in  (acc_lo),
    .rem_out (div_rem),
    .quo_out (div_quo)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    acc_hi_n   = acc_hi;
    acc_lo_n   = acc_lo;
    cnt_n      = cnt;
    res_load   = 1'b0;
    res_n      = result;
    mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
    case (state)
      ST_IDLE: begin
        if (start && !flush) begin
          stall = 1'b1;
          cnt_n = '0;
          acc_hi_n = '0;
          if (funct3[2]) begin
            acc_lo_n = abs_a;
            if (div_zero || div_ovf) begin
              state_next = ST_DONE;
              res_load   = 1'b1;
              res_n      = special_res;
            end else begin
              state_next = ST_DIV;
            end
          end else begin
            acc_lo_n = abs_b;
`ifdef RV_MUL_SINGLECYCLE_EN
            state_next = ST_DONE;
            res_load   = 1'b1;
            res_n      = finish_result(in_op, in_sa, in_sb, fast_prod, '0, '0);
`else
            state_next = ST_MUL;
`endif
          end
        end
      end
      ST_MUL: begin
        stall = 1'b1;
        // Add-then-shift-right: the product grows into acc_hi as the
        // multiplier bits are consumed from the bottom of acc_lo.
        acc_hi_n = mul_sum[32:1];
        acc_lo_n = {mul_sum[0], acc_lo[31:1]};
        cnt_n    = cnt + 6'd1;
        if (cnt_n == 6'(MULDIV_STEPS)) begin
          state_next = ST_DONE;
          res_load   = 1'b1;
          res_n      = finish_result(op, sign_a, sign_b, {acc_hi_n, acc_lo_n}, '0, '0);
        end
      end
      ST_DIV: begin
        stall    = 1'b1;
        acc_hi_n = div_rem;
        acc_lo_n = div_quo;
        cnt_n    = cnt + 6'd1;
        if (cnt_n == 6'(MULDIV_STEPS)) begin
          state_next = ST_DONE;
          res_load   = 1'b1;
          res_n      = finish_result(op, sign_a, sign_b, 64'd0, div_quo, div_rem);
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // A flush abandons the op without touching result or the accumulators.
    if (flush) begin
      state_next = ST_IDLE;
      res_load   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op     <= OP_MUL;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      if (accept) begin
        op     <= in_op;
        sign_a <= in_sa;
        sign_b <= in_sb;
        opnd   <= funct3[2] ? abs_b : abs_a;
      end
      acc_hi <= acc_hi_n;
      acc_lo <= acc_lo_n;
      cnt    <= cnt_n;
      if (res_load) result <= res_n;
      done   <= (state_next == ST_DONE);
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

- Multi-cycle RV32M multiply/divide unit in the EX stage.
- Consumes post-forwarding operands (the values already selected by the forwarding muxes) plus funct3 of an M-extension instruction.
- Holds the pipeline through `stall` while an operation iterates, then presents the 32-bit result for one cycle so the EX/MEM register captures it.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.

Ports:
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: EX holds a valid M-extension instruction (already qualified by not-flushed).
- `funct3` in 3: op select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `operandA` in 32: forwarded rs1 value.
- `operandB` in 32: forwarded rs2 value.
- `flush` in 1: kill the in-flight operation.
- `stall` out 1: freeze IF/ID/EX.
- `busy` out 1: FSM not in IDLE.
- `done` out 1: one-cycle pulse, `result` valid.
- `result` out 32: rd write value.

## Operation
FSM states: IDLE, MUL, DIV, DONE.

- **IDLE**
  - On `start & ~flush`: latch `funct3`, latch |operandA| and |operandB| (signedness per op), record result sign, clear 6-bit counter.
  - funct3[2]=0 goes to MUL; funct3[2]=1 goes to DIV.
  - Special divisions go straight to DONE:
    - Divide by zero: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = operandA.
    - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV = 0x80000000; REM = 0.
- **MUL**
  - One shift-add step per cycle; 64-bit product accumulator.
  - After 32 steps (counter reaches 32) go to DONE.
- **DIV**
  - One restoring step per cycle (subtract, compare, shift quotient bit).
  - After 32 steps go to DONE.
- **DONE**
  - `result` holds the selected word:
    - MUL: product[31:0].
    - MULH/MULHSU/MULHU: product[63:32].
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Sign fix: negate the full 64-bit product when the product sign is set. Quotient sign = signA ^ signB. Remainder sign = signA.
  - `start` is ignored in DONE (it is still the same held instruction). Next state is always IDLE.

Outputs and controls:
- `stall` = (IDLE & `start` & ~`flush`) | MUL | DIV. It is low in DONE so the pipeline advances and captures `result`.
- `flush` in any state: next state IDLE, `done` not pulsed, accumulators not cleared.
- `busy` = state != IDLE.
- `done` is registered and is high exactly in DONE.
- Reset: state IDLE, `result`=0, `done`=0, `busy`=0, counter=0, accumulators=0. `stall` is then combinationally 0 unless `start`=1.
- Asserting `reset_n` low mid-operation aborts it immediately.

## Timing
- `start` accepted in cycle T.
- Iterative MUL/DIV: steps in T+1..T+32; DONE/`done` in T+33; `stall` high T..T+32. Total EX occupancy 34 cycles.
- Special-case divisions: DONE at T+1; `stall` high only in T.
- Back-to-back M instructions: the second instruction reaches EX in T+34 (IDLE) and is accepted there; there are no dead cycles beyond DONE.
- `flush` and `start` in the same cycle: `flush` wins and the op is not accepted.

## Configuration
- `RV_MUL_SINGLECYCLE_EN` defined:
  - MUL* ops compute a 64-bit combinational product at acceptance, register it, and enter DONE at T+1.
  - `stall` is high only in cycle T; the MUL state is unused.
- Undefined: iterative 32-step shift-add as above.
- Division is iterative in both builds.

## Structure
- Shared package `muldiv_pkg`:
  - `muldiv_op_e` (funct3 encodings above).
  - `muldiv_state_e`.
  - `MULDIV_STEPS` = 32.
  - Div-by-zero/overflow result constants.
- One sub-module, `div_step`: combinational single restoring-division step (remainder, divisor, quotient in; next remainder/quotient out). Instantiated once.
- The multiply step, sign fix and result select stay inline.

## Test plan
- MUL 7 × -3, start in T → `stall` high T..T+32, `done` at T+33, `result` 0xFFFFFFEB; with macro, `done` at T+1.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU -1 × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; each `done` at T+33.
- DIVU 5/0 → 0xFFFFFFFF at T+1; REM 5/0 → 5; DIV 0x80000000/-1 → 0x80000000; REM → 0.
- `flush` asserted at T+10 of a DIV → IDLE at T+11, no `done` pulse, `stall` low. A new MUL accepted at T+11 completes correctly.
- `reset_n` pulsed low at T+5 of a MUL → outputs 0 immediately, state IDLE. `start` held high after release restarts the op from step 0.
